pipe_scheduler: RTL
===================

# pipe_scheduler

Game-level controller for the scrolling pipe obstacles. Owns a small pool of pipe slots, spawns pipes at a fixed frame interval with pseudo-random gap heights, scrolls them left at a score-dependent speed, retires them at the left edge, and counts score as pipes pass the bird. Runs on the frame clock beside the bird motion logic and feeds pipe positions to the sprite/colour mapper and the collision checker.

## Interface
- NUM_PIPES, 3: slot count, legal 1..4
- X_SPAWN, 639: X loaded into a newly spawned pipe
- SPAWN_INTERVAL, 120: frames between spawn attempts, ≥2
- GAP_MIN, 100: gap centre Y = GAP_MIN + lfsr (range GAP_MIN..GAP_MIN+255)
- SPEED_DIV, 10: points per speed step
- MAX_SPEED, 4: scroll speed cap, px/frame, ≤7
- LFSR_SEED, 8'hA5: LFSR reset value, nonzero
- frame_clk  in  1  frame clock; all state changes on its rising edge
- Reset_n  in  1  reset, synchronous, active-low
- start  in  1  level flap/start key (keycode==8'h1A decoded upstream)
- collide  in  1  level from collision checker
- bird_x  in  10  bird X centre
- pipe_x  out  10*NUM_PIPES  slot i at [10i+9:10i]
- pipe_gap_y  out  10*NUM_PIPES  gap centre Y per slot, same packing
- pipe_active  out  NUM_PIPES  slot valid
- score  out  27  points, saturates at 2^27-1
- speed  out  3  current scroll speed
- game_state  out  2  0=IDLE, 1=RUN, 2=OVER

## Operation
- Reset (Reset_n=0 at edge): state IDLE, all pipe_x/pipe_gap_y/pipe_active=0, score=0, speed=1, spawn_cnt=0, pts_cnt=0, lfsr=LFSR_SEED, start_q=0.
- start_q registers start every frame; start_edge = start & ~start_q.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, shifts left every frame in every state, feedback into bit 0.
- IDLE: pipes held cleared. start_edge -> RUN; same edge clears score, speed=1, pts_cnt=0, spawn_cnt=SPAWN_INTERVAL-1 (first spawn on first RUN frame). collide ignored.
- RUN, collide=1: -> OVER; that frame no movement, spawn, or scoring.
- RUN, collide=0, per active slot (using pre-update values):
  - crossing if x ≥ bird_x and x < bird_x + speed; credits = count of crossings this frame
  - if x ≤ speed: active<=0, x<=0 (retire); else x<=x-speed
- Scoring: score += credits (saturating). pts_cnt += credits; if result ≥ SPEED_DIV, subtract SPEED_DIV and speed<=min(speed+1, MAX_SPEED).
- Spawn: spawn_cnt counts 0..SPAWN_INTERVAL-1, wraps to 0. On the frame it equals SPAWN_INTERVAL-1, lowest-index slot with pre-update active=0 gets active=1, x=X_SPAWN, gap_y=GAP_MIN+lfsr (current value). No free slot: attempt dropped, counter still wraps. A slot retiring this frame is not free until next frame.
- OVER: everything frozen except LFSR. start_edge -> IDLE, pipes cleared, score/speed held for display until next RUN.
- start held high from IDLE causes exactly one transition (edge-detected).

## Timing
- All outputs registered; response visible on outputs the frame after the triggering edge.
- Latency start_edge -> RUN: 1 frame; first pipe active at X_SPAWN 1 frame after entering RUN.
- collide -> OVER: 1 frame; positions on output equal those presented on the collide frame.
- Reset_n dominates all other inputs, any state.
- Width rules: x - speed computed only when x > speed (no underflow); bird_x + speed in 11 bits; gap sum in 10 bits.

## Test plan
- Reset then idle 50 frames -> game_state=0, pipe_active=0, score=0, speed=1; start held 10 frames -> RUN once, pipe 0 active, x=639, gap_y=100+lfsr.
- RUN 121 frames, bird_x=200, collide=0 -> slot 1 spawns at frame 120, slot 0 at x=639-120=519; score increments by 1 exactly when slot 0 passes x∈[200,200] at speed 1.
- Force 10 crossings (SPEED_DIV=10) -> speed=2, subsequent pipes step by 2, crossing window [bird_x, bird_x+1]; 40 points -> speed capped at 4.
- NUM_PIPES=1, SPAWN_INTERVAL=120, pipe not yet retired -> spawn dropped, no overwrite; pipe at x≤speed retires, next spawn attempt fills slot.
- collide asserted mid-run -> OVER next frame, pipe_x/score unchanged for 100 frames; start edge -> IDLE, pipes cleared, score held; another edge -> score=0.
- Reset_n=0 mid-RUN with 3 active pipes -> next frame all outputs at reset values, lfsr reseeded (next spawn gap_y reproducible).

Source files
------------

// File: rtl/pipe_scheduler.sv
// -----------------------------------------------------------------------------
// pipe_scheduler
// Game-level controller for the scrolling pipe obstacles. Keeps a small pool of
// pipe slots, spawns a pipe every SPAWN_INTERVAL frames with an LFSR-derived
// gap height, scrolls active pipes left at a score-dependent speed, retires
// them at the left edge and scores each pipe as it passes the bird.
//
// Ports
//   frame_clk    in   1             frame clock, all state changes on rising edge
//   Reset_n      in   1             synchronous active-low reset
//   start        in   1             flap/start key level (edge-detected here)
//   collide      in   1             collision level from the collision checker
//   bird_x       in   10            bird X centre
//   pipe_x       out  10*NUM_PIPES  slot i X at [10i+9:10i]
//   pipe_gap_y   out  10*NUM_PIPES  slot i gap centre Y, same packing
//   pipe_active  out  NUM_PIPES     slot valid
//   score        out  27            points, saturating
//   speed        out  3             scroll speed in px/frame
//   game_state   out  2             0=IDLE, 1=RUN, 2=OVER
// -----------------------------------------------------------------------------
module pipe_scheduler #(
    parameter int         NUM_PIPES      = 3,
    parameter int         X_SPAWN        = 639,
    parameter int         SPAWN_INTERVAL = 120,
    parameter int         GAP_MIN        = 100,
    parameter int         SPEED_DIV      = 10,
    parameter int         MAX_SPEED      = 4,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic                    start,
    input  logic                    collide,
    input  logic [9:0]              bird_x,
    output logic [10*NUM_PIPES-1:0] pipe_x,
    output logic [10*NUM_PIPES-1:0] pipe_gap_y,
    output logic [NUM_PIPES-1:0]    pipe_active,
    output logic [26:0]             score,
    output logic [2:0]              speed,
    output logic [1:0]              game_state
);

    localparam int CNT_W = $clog2(SPAWN_INTERVAL);
    // Wide enough for the running remainder plus one frame's worth of credits.
    localparam int PTS_W = $clog2(SPEED_DIV + NUM_PIPES + 1);

    localparam logic [CNT_W-1:0] SPAWN_LAST  = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [PTS_W-1:0] SPEED_DIV_L = PTS_W'(SPEED_DIV);
    localparam logic [2:0]       MAX_SPEED_L = 3'(MAX_SPEED);
    localparam logic [9:0]       X_SPAWN_L   = 10'(X_SPAWN);
    localparam logic [9:0]       GAP_MIN_L   = 10'(GAP_MIN);
    localparam logic [26:0]      SCORE_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NUM_PIPES-1:0][9:0]  r_x;
    logic [NUM_PIPES-1:0][9:0]  r_gap;
    logic [NUM_PIPES-1:0]       r_active;
    logic [26:0]                r_score;
    logic [2:0]                 r_speed;
    logic [CNT_W-1:0]           r_spawn_cnt;
    logic [PTS_W-1:0]           r_pts_cnt;
    logic [7:0]                 r_lfsr;
    logic                       r_start_q;

    state_t                     w_state_next;
    logic                       w_start_edge;
    logic                       w_clear;
    logic                       w_advance;
    logic                       w_spawn_now;
    logic [7:0]                 w_lfsr_next;
    logic [10:0]                w_reach;
    logic [2:0]                 w_credits;
    logic [NUM_PIPES-1:0]       w_spawn_sel;
    logic                       w_taken;
    logic [27:0]                w_score_sum;
    logic [PTS_W-1:0]           w_pts_sum;
    logic                       w_speed_up;

    assign w_start_edge = start & ~r_start_q;
    // x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3, shifted in at bit 0.
    assign w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_reach      = {1'b0, bird_x} + {8'b0, r_speed};
    assign w_spawn_now  = w_advance && (r_spawn_cnt == SPAWN_LAST);
    assign w_score_sum  = {1'b0, r_score} + {25'b0, w_credits};
    assign w_pts_sum    = r_pts_cnt + PTS_W'(w_credits);
    assign w_speed_up   = (w_pts_sum >= SPEED_DIV_L);

    // Next state and per-frame control strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (w_start_edge) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (collide) w_state_next = ST_OVER;
                else         w_advance    = 1'b1;
            end
            ST_OVER: begin
                if (w_start_edge) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Crossing credits and lowest-index free slot, both from pre-update values,
    // so a slot retiring this frame is never chosen for a spawn.
    always_comb begin
        w_credits   = '0;
        w_spawn_sel = '0;
        w_taken     = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_active[i] && (r_x[i] >= bird_x) && ({1'b0, r_x[i]} < w_reach))
                w_credits = w_credits + 3'd1;
            if (!r_active[i] && !w_taken) begin
                w_spawn_sel[i] = 1'b1;
                w_taken        = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            // NOTE: the slot file is a handful of flops, not a RAM, so it is reset with everything else.
            r_x         <= '0;
            r_gap       <= '0;
            r_active    <= '0;
            r_score     <= '0;
            r_speed     <= 3'd1;
            r_spawn_cnt <= '0;
            r_pts_cnt   <= '0;
            r_lfsr      <= LFSR_SEED;
            r_start_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_next;
            r_start_q <= start;
            r_lfsr    <= w_lfsr_next;

            if (w_clear) begin
                r_x      <= '0;
                r_gap    <= '0;
                r_active <= '0;
            end else if (w_advance) begin
                for (int i = 0; i < NUM_PIPES; i++) begin
                    if (r_active[i]) begin
                        // Subtraction only taken when x > speed, so it cannot wrap.
                        if (r_x[i] <= {7'b0, r_speed}) begin
                            r_active[i] <= 1'b0;
                            r_x[i]      <= '0;
                        end else begin
                            r_x[i] <= r_x[i] - {7'b0, r_speed};
                        end
                    end else if (w_spawn_now && w_spawn_sel[i]) begin
                        r_active[i] <= 1'b1;
                        r_x[i]      <= X_SPAWN_L;
                        r_gap[i]    <= GAP_MIN_L + {2'b0, r_lfsr};
                    end
                end
            end

            if (r_state == ST_IDLE && w_start_edge) begin
                r_score     <= '0;
                r_speed     <= 3'd1;
                r_pts_cnt   <= '0;
                r_spawn_cnt <= SPAWN_LAST;
            end else if (w_advance) begin
                r_score     <= w_score_sum[27] ? SCORE_MAX : w_score_sum[26:0];
                r_spawn_cnt <= (r_spawn_cnt == SPAWN_LAST) ? '0 : r_spawn_cnt + 1'b1;
                if (w_speed_up) begin
                    r_pts_cnt <= w_pts_sum - SPEED_DIV_L;
                    if (r_speed < MAX_SPEED_L) r_speed <= r_speed + 3'd1;
                end else begin
                    r_pts_cnt <= w_pts_sum;
                end
            end
        end
    end

    assign pipe_x      = r_x;
    assign pipe_gap_y  = r_gap;
    assign pipe_active = r_active;
    assign score       = r_score;
    assign speed       = r_speed;
    assign game_state  = r_state;

endmodule
